// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the MEM-stage data memory.
//   - access-size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   - NUM_LANES: byte lanes per 32-bit word
//   - req_meta_t: request attributes carried down the response pipeline
//   - byte_en(size, offset): per-lane write/select enables
//   - misaligned(size, offset): alignment violation for half/word
package dmem_pkg;

   localparam int NUM_LANES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef struct packed {
      logic       err;
      logic       we;
      logic       uns;
      logic [1:0] size;
      logic [1:0] off;
   } req_meta_t;

   function automatic logic [NUM_LANES-1:0] byte_en(input logic [1:0] size,
                                                    input logic [1:0] off);
      logic [NUM_LANES-1:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic misaligned(input logic [1:0] size,
                                       input logic [1:0] off);
      return ((size == SZ_HALF) && off[0]) ||
             ((size == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational lane alignment.
//   Store side: replicates byte/half store data across all lanes so the
//   byte enables alone pick the destination lane.
//   Load side: shifts the selected lanes down to bit 0 and sign- or
//   zero-extends bytes and halves.
// Ports:
//   st_size, st_wdata -> st_lanes          (request path)
//   ld_word, ld_size, ld_off, ld_unsigned -> ld_data (response path)
module dmem_align
   import dmem_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_lanes,
   input  logic [31:0] ld_word,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_unsigned,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      st_lanes = st_wdata;
      case (st_size)
         SZ_BYTE: st_lanes = {4{st_wdata[7:0]}};
         SZ_HALF: st_lanes = {2{st_wdata[15:0]}};
         default: st_lanes = st_wdata;
      endcase
   end

   // Legal word loads always have offset 0, so the shifted value is the word.
   always_comb begin
      shifted = ld_word >> {ld_off, 3'b000};
      ld_data = shifted;
      case (ld_size)
         SZ_BYTE: ld_data = {{24{~ld_unsigned & shifted[7]}},  shifted[7:0]};
         SZ_HALF: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage data memory with valid/ready request and response.
//   Byte/half/word loads and stores, sign/zero extension, error flagging
//   for reserved size, misalignment and out-of-range addresses. Every
//   accepted request yields one response LAT cycles later (LAT = 1 or 2).
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready, req_we, req_size, req_unsigned, req_addr, req_wdata
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err
//   err_count[15:0] (only when DMEM_ERR_CNT_EN is defined): saturating
//   count of errored requests.
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
`ifdef DMEM_ERR_CNT_EN
   ,output logic [15:0]      err_count
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0]    mem [DEPTH];
   logic                 ready_q;
   logic                 advance;
   logic                 accept;
   logic [IDX_W-1:0]     idx;
   logic [1:0]           off;
   logic                 req_err;
   logic [NUM_LANES-1:0] be;
   logic [31:0]          st_lanes;
   logic [31:0]          ld_data;
   logic                 s1_valid;
   req_meta_t            s1_meta;
   logic [31:0]          s1_word;
   logic [31:0]          s1_rdata;

   assign idx     = req_addr[IDX_W+1:2];
   assign off     = req_addr[1:0];
   assign req_err = (req_size == SZ_RSVD) || misaligned(req_size, off) ||
                    ((req_addr >> (IDX_W + 2)) != '0);
   assign be      = byte_en(req_size, off);

   // The pipeline moves only when the output slot is free or being drained.
   assign advance   = !rsp_valid || rsp_ready;
   assign req_ready = ready_q && advance;
   assign accept    = req_valid && req_ready;

   // Holds req_ready low until the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ready_q <= 1'b0;
      else     ready_q <= 1'b1;
   end

   dmem_align u_align (
      .st_size     (req_size),
      .st_wdata    (req_wdata),
      .st_lanes    (st_lanes),
      .ld_word     (s1_word),
      .ld_size     (s1_meta.size),
      .ld_off      (s1_meta.off),
      .ld_unsigned (s1_meta.uns),
      .ld_data     (ld_data)
   );

   // Array is not reset. A store is written at its acceptance edge, so any
   // later request reads the updated word.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_word <= mem[idx];
         if (req_we && !req_err) begin
            for (int i = 0; i < NUM_LANES; i++) begin
               if (be[i]) mem[idx][8*i +: 8] <= st_lanes[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_meta  <= '0;
      end else if (advance) begin
         s1_valid <= accept;
         if (accept) begin
            s1_meta.err  <= req_err;
            s1_meta.we   <= req_we;
            s1_meta.uns  <= req_unsigned;
            s1_meta.size <= req_size;
            s1_meta.off  <= off;
         end
      end
   end

   assign s1_rdata = (s1_valid && !s1_meta.err && !s1_meta.we) ? ld_data : '0;

   if (LAT == 2) begin : g_lat2
      logic        s2_valid;
      logic        s2_err;
      logic [31:0] s2_rdata;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s2_valid <= 1'b0;
            s2_err   <= 1'b0;
            s2_rdata <= '0;
         end else if (advance) begin
            s2_valid <= s1_valid;
            s2_err   <= s1_valid && s1_meta.err;
            s2_rdata <= s1_rdata;
         end
      end

      assign rsp_valid = s2_valid;
      assign rsp_err   = s2_err;
      assign rsp_rdata = s2_rdata;
   end else begin : g_lat1
      assign rsp_valid = s1_valid;
      assign rsp_err   = s1_valid && s1_meta.err;
      assign rsp_rdata = s1_rdata;
   end

`ifdef DMEM_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         err_count <= '0;
      else if (accept && req_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
   import dmem_pkg::*;

   localparam int DEPTH = 256;
   localparam int LAT   = 1;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef DMEM_ERR_CNT_EN
   logic [15:0] err_count;
   logic [15:0] cnt0;
`endif

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic        exp_err;
   logic [31:0] exp_data;
   int          errors = 0;
   int          checks = 0;

   dmem_lsu #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LAT(LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
`ifdef DMEM_ERR_CNT_EN
      ,.err_count   (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: push at acceptance, pop and compare at response hand-off.
   // Both are decided from values stable between negedge+2 and the next posedge.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rsp: got err=%0b data=%h, required no response", rsp_err, rsp_rdata);
            end else begin
               mon_e = sb.pop_front();
               if (rsp_err !== mon_e.err || rsp_rdata !== mon_e.data) begin
                  errors++;
                  $display("FAIL rsp: got err=%0b data=%h, required err=%0b data=%h",
                           rsp_err, rsp_rdata, mon_e.err, mon_e.data);
               end
            end
         end
         if (req_valid && req_ready) begin
            mon_e.err  = exp_err;
            mon_e.data = exp_data;
            sb.push_back(mon_e);
         end
      end
   end

   // Drives one request from a negedge and returns right after the edge that accepts it.
   task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_data);
      bit acc;
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd; exp_err = e_err; exp_data = e_data;
      n = 0;
      forever begin
         #2;
         acc = req_ready;
         @(posedge clk);
         if (acc) break;
         n++;
         if (n > 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: addr=%h not accepted after %0d cycles, required acceptance", addr, n);
            req_valid = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b, required 0", rsp_valid); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %0b, required 0", rsp_err); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h, required 0", rsp_rdata); end
`ifdef DMEM_ERR_CNT_EN
      checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err_count: got %0d, required 0", err_count); end
`endif
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b, required 1", req_ready); end
   endtask

   task automatic test_word();
      send(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0);
      idle();
      drain();
      send(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
      for (int i = 1; i <= LAT; i++) begin
         @(negedge clk);
         if (i == 1) req_valid = 1'b0;
         #1;
         checks++;
         if (rsp_valid !== (i == LAT)) begin
            errors++;
            $display("FAIL word_latency: cycle %0d rsp_valid got %0b, required %0b", i, rsp_valid, (i == LAT));
         end
      end
      drain();
   endtask

   task automatic test_byte();
      send(1, SZ_WORD, 0, 32'h10, 32'h11223344, 0, 32'h0);
      send(1, SZ_BYTE, 0, 32'h13, 32'h123456A5, 0, 32'h0);
      send(0, SZ_BYTE, 0, 32'h13, 32'h0, 0, 32'hFFFFFFA5);
      send(0, SZ_BYTE, 1, 32'h13, 32'h0, 0, 32'h000000A5);
      send(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hA5223344);
      send(0, SZ_BYTE, 0, 32'h10, 32'h0, 0, 32'h00000044);
      send(0, SZ_BYTE, 1, 32'h11, 32'h0, 0, 32'h00000033);
      send(0, SZ_HALF, 0, 32'h12, 32'h0, 0, 32'hFFFFA522);
      idle();
      drain();
   endtask

   task automatic test_half();
      send(1, SZ_WORD, 0, 32'h20, 32'h55667788, 0, 32'h0);
      send(1, SZ_HALF, 0, 32'h22, 32'hCDEF8001, 0, 32'h0);
      send(0, SZ_HALF, 0, 32'h22, 32'h0, 0, 32'hFFFF8001);
      send(0, SZ_HALF, 1, 32'h22, 32'h0, 0, 32'h00008001);
      send(0, SZ_WORD, 0, 32'h20, 32'h0, 0, 32'h80017788);
      send(0, SZ_HALF, 0, 32'h20, 32'h0, 0, 32'h00007788);
      send(1, SZ_BYTE, 0, 32'h21, 32'h000000F0, 0, 32'h0);
      send(0, SZ_BYTE, 0, 32'h21, 32'h0, 0, 32'hFFFFFFF0);
      send(0, SZ_WORD, 0, 32'h20, 32'h0, 0, 32'h8001F088);
      idle();
      drain();
   endtask

   task automatic test_errors();
      send(1, SZ_WORD, 0, 32'h0, 32'h0BADF00D, 0, 32'h0);
      idle();
      drain();
`ifdef DMEM_ERR_CNT_EN
      cnt0 = err_count;
`endif
      send(0, SZ_HALF, 0, 32'h21, 32'h0, 1, 32'h0);
      send(1, SZ_WORD, 0, 32'h22, 32'hFFFFFFFF, 1, 32'h0);
      send(0, SZ_WORD, 0, DEPTH * 4, 32'h0, 1, 32'h0);
      send(1, SZ_WORD, 0, DEPTH * 4, 32'hFFFFFFFF, 1, 32'h0);
      send(1, SZ_RSVD, 0, 32'h20, 32'hFFFFFFFF, 1, 32'h0);
      send(0, SZ_WORD, 0, 32'h20, 32'h0, 0, 32'h8001F088);
      send(0, SZ_WORD, 0, 32'h0, 32'h0, 0, 32'h0BADF00D);
      idle();
      drain();
`ifdef DMEM_ERR_CNT_EN
      checks++;
      if (err_count !== cnt0 + 16'd5) begin
         errors++;
         $display("FAIL err_count: got %0d, required %0d", err_count, cnt0 + 16'd5);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int n;
      int hs;
      rsp_ready = 1'b0;
      send(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hA5223344);
      idle();
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      fork
         begin
            send(1, SZ_WORD, 0, 32'h10, 32'h99999999, 0, 32'h0);
            send(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'h99999999);
            send(0, SZ_BYTE, 1, 32'h11, 32'h0, 0, 32'h00000099);
            idle();
         end
         begin
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               #1;
               checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready: cycle %0d got %0b, required 0", i, req_ready); end
               checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_rsp_valid: cycle %0d got %0b, required 1", i, rsp_valid); end
               checks++; if (rsp_rdata !== 32'hA5223344 || rsp_err !== 1'b0) begin
                  errors++; $display("FAIL stall_rsp_hold: cycle %0d got err=%0b data=%h, required err=0 data=a5223344", i, rsp_err, rsp_rdata);
               end
            end
            @(negedge clk);
            rsp_ready = 1'b1;
            hs = 0;
            for (int i = 0; i <= 2 + LAT; i++) begin
               if (i > 0) @(negedge clk);
               #3;
               if (rsp_valid && rsp_ready) hs++;
            end
            checks++;
            if (hs !== 4) begin errors++; $display("FAIL b2b_handoffs: got %0d in %0d cycles, required 4", hs, 3 + LAT); end
            @(negedge clk);
            #3;
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: rsp_valid got %0b, required 0", rsp_valid); end
         end
      join
      drain();
   endtask

   task automatic test_reset_inflight();
      send(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'h99999999);
      #1;
      rst = 1'b1;
      req_valid = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight_valid: got %0b, required 0", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_inflight_rdata: got %h, required 0", rsp_rdata); end
      sb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: cycle %0d rsp_valid got %0b, required 0", i, rsp_valid); end
      end
`ifdef DMEM_ERR_CNT_EN
      checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL rst_err_count: got %0d, required 0", err_count); end
`endif
      send(0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'h99999999);
      send(0, SZ_WORD, 0, 32'h20, 32'h0, 0, 32'h8001F088);
      idle();
      drain();
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1; exp_err = 1'b0; exp_data = 32'h0;
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_back_to_back();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Parametrised data memory for the pipelined RISC-V core's MEM stage, with a valid/ready request and response handshake.
- Supports byte, half and word loads and stores with correct lane placement, and sign/zero extension on loads.
- Flags misaligned and out-of-range accesses instead of silently corrupting memory.
- Replaces the fixed 64-word memory; MEM-stage stall logic consumes the handshake.

Parameters:
- DATA_W, 32, data width in bits; must be 32 (byte lanes fixed at 4).
- DEPTH, 256, number of 32-bit words; power of two, 4 to 65536.
- ADDR_W, 32, request byte-address width.
- LAT, 1, read latency in cycles; 1 or 2 (2 adds an output register stage).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error).
- req_unsigned  in  1  load zero-extends when 1 (LBU/LHU); ignored for stores and words.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low-order bits are used for byte and half stores.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or reserved-size access.

Behaviour:
- Reset (async assert): rsp_valid=0, rsp_rdata=0, rsp_err=0, pipeline stages emptied, any in-flight request dropped.
  - Memory array contents are not reset.
  - req_ready=1 from the first edge after deassert.
- Acceptance: a request is accepted on a rising edge when req_valid && req_ready.
  - req_ready = !(stage occupied) || (rsp_valid && rsp_ready), so one response can be outstanding per latency stage.
- Every accepted request, loads and stores alike, produces exactly one response, LAT cycles after acceptance.
  - The response is held stable (rsp_valid, rsp_rdata, rsp_err) until rsp_ready=1.
- Word index = req_addr[log2(DEPTH)+1:2]; byte offset = req_addr[1:0].
- Error if any of:
  - req_size==11;
  - half with offset[0]=1;
  - word with offset!=0;
  - req_addr[ADDR_W-1:log2(DEPTH)+2] != 0.
  - On error: no memory write, rsp_err=1, rsp_rdata=0.
- Store lanes: write enables derived per byte.
  - Byte at offset k writes bits [8k+7:8k] from wdata[7:0].
  - Half at offset 0 writes [15:0], at offset 2 writes [31:16], both from wdata[15:0].
  - Word writes all lanes.
  - Unselected lanes are unchanged.
- Loads select the same lanes, then sign-extend from bit 7 or 15 (req_unsigned=0) or zero-extend (req_unsigned=1).
- Store followed by load of the same word on the next accepted request returns the new data (write-first array, no hazard).
- Simultaneous response hand-off and new acceptance in the same cycle is legal; full throughput is 1 request per cycle when rsp_ready is held at 1.
- Backpressure: while rsp_valid && !rsp_ready, no new acceptance and no memory write occurs.

Optional Feature:
- Macro DMEM_ERR_CNT_EN adds output err_count [15:0].
- With the macro: err_count increments by 1 on each errored request at acceptance and saturates at 16'hFFFF; reset value is 0.
- Without the macro: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - lane count constant;
  - function byte_en(size, offset) returning 4-bit enables;
  - function misaligned(size, offset).
- Sub-module dmem_align (combinational): load lane select plus extension, and store data replication to lanes. It is instantiated once, on the request path for stores and on the response path for loads.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly LAT cycles after acceptance.
- Byte store 0xA5 @0x13 over word 0x11223344, then LB @0x13 -> 0xFFFFFFA5; LBU @0x13 -> 0x000000A5; word load -> 0xA5223344.
- Half store 0x8001 @0x22, then LH -> 0xFFFF8001, LHU -> 0x00008001; word @0x20 upper half = 0x8001, lower half unchanged.
- LH @0x21, SW @0x22, access @(DEPTH*4) -> rsp_err=1, rsp_rdata=0, memory unchanged; err_count=3 with DMEM_ERR_CNT_EN.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable, no extra writes; release -> back-to-back 1/cycle responses in order.
- Assert rst while a load is in flight -> rsp_valid=0 immediately; no response after deassert; memory retains prior data.
